// File: rtl/dffram_arbiter.sv
// Shares one single-port DFFRAM between the mgmt core port and a read-only housekeeping port.
// Each access walks IDLE -> ACC -> RD -> ACK; starve_cnt bounds how long housekeeping waits.
module dffram_arbiter #(
    parameter int unsigned AW              = 8,
    parameter int unsigned DW              = 32,
    parameter int unsigned MAX_CORE_GRANTS = 2
) (
    input  logic          core_clk,
    input  logic          core_rst,
    input  logic          m_req,
    input  logic [3:0]    m_we,
    input  logic [AW-1:0] m_addr,
    input  logic [DW-1:0] m_wdata,
    output logic          m_ack,
    output logic [DW-1:0] m_rdata,
    input  logic          h_req,
    input  logic [AW-1:0] h_addr,
    output logic          h_ack,
    output logic [DW-1:0] h_rdata,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StAcc, StRd, StAck} state_e;

    localparam logic [3:0] MaxGrants = 4'(MAX_CORE_GRANTS);

    state_e     state_q;
    logic       owner_hk_q;
    logic [3:0] starve_cnt_q;
    logic       grant_hk;

    // Housekeeping wins when alone, or once the core has used up its consecutive grants.
    assign grant_hk = h_req && (!m_req || (starve_cnt_q >= MaxGrants));

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q      <= StIdle;
            owner_hk_q   <= 1'b0;
            starve_cnt_q <= 4'd0;
            ram_en       <= 1'b0;
            ram_we       <= 4'd0;
            ram_a        <= '0;
            ram_di       <= '0;
            m_ack        <= 1'b0;
            h_ack        <= 1'b0;
            m_rdata      <= '0;
            h_rdata      <= '0;
            busy         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (m_req || h_req) begin
                        state_q    <= StAcc;
                        busy       <= 1'b1;
                        ram_en     <= 1'b1;
                        owner_hk_q <= grant_hk;
                        if (grant_hk) begin
                            ram_a        <= h_addr;
                            ram_we       <= 4'd0;
                            ram_di       <= '0;
                            starve_cnt_q <= 4'd0;
                        end else begin
                            ram_a  <= m_addr;
                            ram_we <= m_we;
                            ram_di <= m_wdata;
                            if (!h_req) begin
                                starve_cnt_q <= 4'd0;
                            end else if (starve_cnt_q < MaxGrants) begin
                                starve_cnt_q <= starve_cnt_q + 4'd1;
                            end
                        end
                    end else begin
                        starve_cnt_q <= 4'd0;
                    end
                end
                StAcc: begin
                    state_q <= StRd;
                    ram_en  <= 1'b0;
                    ram_we  <= 4'd0;
                    ram_di  <= '0;
                end
                StRd: begin
                    state_q <= StAck;
                    if (owner_hk_q) begin
                        h_rdata <= ram_do;
                        h_ack   <= 1'b1;
                    end else begin
                        m_rdata <= ram_do;
                        m_ack   <= 1'b1;
                    end
                end
                StAck: begin
                    // Requests are ignored here so a req still held during its ack is not re-accepted.
                    state_q <= StIdle;
                    m_ack   <= 1'b0;
                    h_ack   <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
